// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
// Sequences every access to the 32 x 19-bit register file: round-robin
// arbitration of two write requesters onto the single write port, a
// registered write stage, and a 2-cycle read transaction on the rs port
// with same-cycle write forwarding.
// Optional statistics counters are built when REGFILE_CTRL_STATS_EN is defined.

`timescale 1ns/1ps

module regfile_access_ctrl #(
   parameter int DATA_W = 19,
   parameter int ADDR_W = 5
`ifdef REGFILE_CTRL_STATS_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr0_valid,
   output logic              wr0_ready,
   input  logic [ADDR_W-1:0] wr0_addr,
   input  logic [DATA_W-1:0] wr0_data,
   input  logic              wr1_valid,
   output logic              wr1_ready,
   input  logic [ADDR_W-1:0] wr1_addr,
   input  logic [DATA_W-1:0] wr1_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_data_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rf_writeenable,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [ADDR_W-1:0] rf_rs,
   output logic [DATA_W-1:0] rf_aluresult,
   input  logic [DATA_W-1:0] rf_regdata1
`ifdef REGFILE_CTRL_STATS_EN
   ,
   output logic [CNT_W-1:0]  stat_wr0_cnt,
   output logic [CNT_W-1:0]  stat_wr1_cnt,
   output logic [CNT_W-1:0]  stat_rd_cnt,
   output logic [CNT_W-1:0]  stat_fwd_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DATA  = 2'd2
   } RdState_t;

   RdState_t          r_state;
   logic              r_favourWr1;
   logic              r_writeEnable;
   logic [ADDR_W-1:0] r_rd;
   logic [DATA_W-1:0] r_aluResult;
   logic [ADDR_W-1:0] r_rs;
   logic              r_rdReady;
   logic              r_rdDataValid;
   logic              r_fwdFlag;
   logic [DATA_W-1:0] r_fwdData;

   logic              w_wr0Grant;
   logic              w_wr1Grant;
   logic              w_grant;
   logic [ADDR_W-1:0] w_grantAddr;
   logic [DATA_W-1:0] w_grantData;
   logic              w_rdHandshake;
   logic              w_fwdHit;
   logic [DATA_W-1:0] w_rdData;

   // A lone requester always wins; under contention the pointer decides.
   assign w_wr0Grant    = wr0_valid && (!wr1_valid || !r_favourWr1);
   assign w_wr1Grant    = wr1_valid && (!wr0_valid ||  r_favourWr1);
   assign w_grant       = w_wr0Grant || w_wr1Grant;
   assign w_grantAddr   = w_wr1Grant ? wr1_addr : wr0_addr;
   assign w_grantData   = w_wr1Grant ? wr1_data : wr0_data;
   assign w_rdHandshake = rd_valid && r_rdReady;
   // The register file samples rs in ISSUE; a write landing on the same
   // edge is not yet in the sampled data, so it must be captured here.
   assign w_fwdHit      = (r_state == ST_ISSUE) && r_writeEnable && (r_rd == r_rs);

   // Round-robin pointer: after a grant, the other requester is favoured.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_favourWr1 <= 1'b0;
      end else if (w_wr0Grant) begin
         r_favourWr1 <= 1'b1;
      end else if (w_wr1Grant) begin
         r_favourWr1 <= 1'b0;
      end
   end

   // Registered write stage; writes to register 0 are swallowed here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_writeEnable <= 1'b0;
         r_rd          <= '0;
         r_aluResult   <= '0;
      end else if (w_grant && (w_grantAddr != '0)) begin
         r_writeEnable <= 1'b1;
         r_rd          <= w_grantAddr;
         r_aluResult   <= w_grantData;
      end else begin
         r_writeEnable <= 1'b0;
         r_rd          <= '0;
      end
   end

   // Read transaction FSM: IDLE accepts, ISSUE lets the file sample rs,
   // DATA presents the result for exactly one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_rs          <= '0;
         r_rdReady     <= 1'b1;
         r_rdDataValid <= 1'b0;
         r_fwdFlag     <= 1'b0;
         r_fwdData     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_rdHandshake) begin
                  r_rs      <= rd_addr;
                  r_rdReady <= 1'b0;
                  r_state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (w_fwdHit) begin
                  r_fwdData <= r_aluResult;
                  r_fwdFlag <= 1'b1;
               end
               r_rdDataValid <= 1'b1;
               r_state       <= ST_DATA;
            end
            ST_DATA: begin
               r_rdDataValid <= 1'b0;
               r_fwdFlag     <= 1'b0;
               r_rdReady     <= 1'b1;
               r_state       <= ST_IDLE;
            end
            default: begin
               r_rdDataValid <= 1'b0;
               r_fwdFlag     <= 1'b0;
               r_rdReady     <= 1'b1;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end

   // Read result: zero register reads as 0, otherwise forwarded or file data.
   always_comb begin
      w_rdData = '0;
      if (r_rdDataValid && (r_rs != '0)) begin
         w_rdData = r_fwdFlag ? r_fwdData : rf_regdata1;
      end
   end

   assign wr0_ready      = w_wr0Grant;
   assign wr1_ready      = w_wr1Grant;
   assign rd_ready       = r_rdReady;
   assign rd_data_valid  = r_rdDataValid;
   assign rd_data        = w_rdData;
   assign rf_writeenable = r_writeEnable;
   assign rf_rd          = r_rd;
   assign rf_rs          = r_rs;
   assign rf_aluresult   = r_aluResult;

`ifdef REGFILE_CTRL_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_wr0Cnt;
   logic [CNT_W-1:0] r_wr1Cnt;
   logic [CNT_W-1:0] r_rdCnt;
   logic [CNT_W-1:0] r_fwdCnt;

   // Saturating event counters for grants, read handshakes and forwards.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr0Cnt <= '0;
         r_wr1Cnt <= '0;
         r_rdCnt  <= '0;
         r_fwdCnt <= '0;
      end else begin
         if (w_wr0Grant    && (r_wr0Cnt != '1)) r_wr0Cnt <= r_wr0Cnt + CNT_ONE;
         if (w_wr1Grant    && (r_wr1Cnt != '1)) r_wr1Cnt <= r_wr1Cnt + CNT_ONE;
         if (w_rdHandshake && (r_rdCnt  != '1)) r_rdCnt  <= r_rdCnt  + CNT_ONE;
         if (w_fwdHit      && (r_fwdCnt != '1)) r_fwdCnt <= r_fwdCnt + CNT_ONE;
      end
   end

   assign stat_wr0_cnt = r_wr0Cnt;
   assign stat_wr1_cnt = r_wr1Cnt;
   assign stat_rd_cnt  = r_rdCnt;
   assign stat_fwd_cnt = r_fwdCnt;
`endif

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl
// Directed bench for regfile_access_ctrl with a behavioural register file
// (registered regdata1, write on the same edge as the sample).

`timescale 1ns/1ps

module tb_regfile_access_ctrl;

   logic        clk;
   logic        reset_n;
   logic        wr0_valid;
   logic        wr0_ready;
   logic [4:0]  wr0_addr;
   logic [18:0] wr0_data;
   logic        wr1_valid;
   logic        wr1_ready;
   logic [4:0]  wr1_addr;
   logic [18:0] wr1_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [4:0]  rd_addr;
   logic        rd_data_valid;
   logic [18:0] rd_data;
   logic        rf_writeenable;
   logic [4:0]  rf_rd;
   logic [4:0]  rf_rs;
   logic [18:0] rf_aluresult;
   logic [18:0] rf_regdata1;
`ifdef REGFILE_CTRL_STATS_EN
   logic [15:0] stat_wr0_cnt;
   logic [15:0] stat_wr1_cnt;
   logic [15:0] stat_rd_cnt;
   logic [15:0] stat_fwd_cnt;
`endif

   int compared   = 0;
   int mismatched = 0;

   logic        tbInit;
   logic [18:0] rfMem [0:31];

   regfile_access_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .wr0_valid      (wr0_valid),
      .wr0_ready      (wr0_ready),
      .wr0_addr       (wr0_addr),
      .wr0_data       (wr0_data),
      .wr1_valid      (wr1_valid),
      .wr1_ready      (wr1_ready),
      .wr1_addr       (wr1_addr),
      .wr1_data       (wr1_data),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .rd_addr        (rd_addr),
      .rd_data_valid  (rd_data_valid),
      .rd_data        (rd_data),
      .rf_writeenable (rf_writeenable),
      .rf_rd          (rf_rd),
      .rf_rs          (rf_rs),
      .rf_aluresult   (rf_aluresult),
      .rf_regdata1    (rf_regdata1)
`ifdef REGFILE_CTRL_STATS_EN
      ,
      .stat_wr0_cnt   (stat_wr0_cnt),
      .stat_wr1_cnt   (stat_wr1_cnt),
      .stat_rd_cnt    (stat_rd_cnt),
      .stat_fwd_cnt   (stat_fwd_cnt)
`endif
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register file model: entry 0 holds junk so the controller must force
   // zero itself; regdata1 is registered and sees pre-write contents.
   always @(posedge clk) begin
      if (tbInit) begin
         for (int i = 0; i < 32; i++) rfMem[i] <= '0;
         rfMem[0]    <= 19'h6A5A5;
         rf_regdata1 <= '0;
      end else begin
         if (rf_writeenable) rfMem[rf_rd] <= rf_aluresult;
         rf_regdata1 <= rfMem[rf_rs];
      end
   end

   // Single-cycle write on one requester followed by two idle cycles.
   task automatic writeReg(input bit useWr1, input logic [4:0] addr, input logic [18:0] data);
      wr0_valid = !useWr1; wr0_addr = addr; wr0_data = data;
      wr1_valid =  useWr1; wr1_addr = addr; wr1_data = data;
      @(posedge clk); #1;
      wr0_valid = 1'b0; wr1_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   // Read handshake in cycle 0, optional wr0 write in cycle wOff; observes
   // six cycles and reports what the controller did.
   task automatic runRead(input logic [4:0] addr, input int wOff, input logic [4:0] wAddr,
                          input logic [18:0] wData, output logic [5:0] readyTrace,
                          output logic wrGranted, output int latency, output int pulses,
                          output logic [18:0] data);
      latency = -1; pulses = 0; data = '0; readyTrace = '0; wrGranted = 1'b0;
      for (int c = 0; c < 6; c++) begin
         rd_valid  = (c == 0); rd_addr  = addr;
         wr0_valid = (c == wOff); wr0_addr = wAddr; wr0_data = wData;
         @(negedge clk);
         readyTrace[c] = rd_ready;
         if (c == wOff) wrGranted = wr0_ready;
         if (rd_data_valid) begin
            pulses++;
            if (latency < 0) begin latency = c; data = rd_data; end
         end
         @(posedge clk); #1;
      end
      rd_valid = 1'b0; wr0_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      compared++; if (rd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_rd_ready: got %0b expected 1", rd_ready); end
      compared++; if (rd_data_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd_data_valid: got %0b expected 0", rd_data_valid); end
      compared++; if (rd_data !== 19'h0) begin mismatched++; $display("[TB] FAIL reset_rd_data: got %05h expected 00000", rd_data); end
      compared++; if (rf_writeenable !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rf_we: got %0b expected 0", rf_writeenable); end
      compared++; if (rf_rd !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_rf_rd: got %0d expected 0", rf_rd); end
      compared++; if (rf_rs !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_rf_rs: got %0d expected 0", rf_rs); end
      compared++; if (rf_aluresult !== 19'h0) begin mismatched++; $display("[TB] FAIL reset_rf_alu: got %05h expected 00000", rf_aluresult); end
      compared++; if ({wr0_ready, wr1_ready} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_wr_ready: got %02b expected 00", {wr0_ready, wr1_ready}); end
`ifdef REGFILE_CTRL_STATS_EN
      compared++; if (stat_fwd_cnt !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_stat_fwd: got %0d expected 0", stat_fwd_cnt); end
`endif
      reset_n = 1'b1;
      tbInit  = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin;
      logic [4:0]  expRd   [4];
      logic [18:0] expData [4];
      expRd   = '{5'd1, 5'd2, 5'd1, 5'd2};
      expData = '{19'h00011, 19'h00022, 19'h00011, 19'h00022};
      for (int k = 0; k < 5; k++) begin
         wr0_valid = (k < 4); wr0_addr = 5'd1; wr0_data = 19'h00011;
         wr1_valid = (k < 4); wr1_addr = 5'd2; wr1_data = 19'h00022;
         @(negedge clk);
         if (k < 4) begin
            compared++;
            if ({wr0_ready, wr1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
               mismatched++; $display("[TB] FAIL rr_grant_%0d: got %02b expected %02b", k, {wr0_ready, wr1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
            end
         end
         if (k == 0) begin
            compared++; if (rf_writeenable !== 1'b0) begin mismatched++; $display("[TB] FAIL rr_we_first: got %0b expected 0", rf_writeenable); end
         end else begin
            compared++; if (rf_writeenable !== 1'b1) begin mismatched++; $display("[TB] FAIL rr_we_%0d: got %0b expected 1", k, rf_writeenable); end
            compared++; if (rf_rd !== expRd[k-1]) begin mismatched++; $display("[TB] FAIL rr_rd_%0d: got %0d expected %0d", k, rf_rd, expRd[k-1]); end
            compared++; if (rf_aluresult !== expData[k-1]) begin mismatched++; $display("[TB] FAIL rr_alu_%0d: got %05h expected %05h", k, rf_aluresult, expData[k-1]); end
         end
         @(posedge clk); #1;
      end
      wr0_valid = 1'b0; wr1_valid = 1'b0;
      @(negedge clk);
      compared++; if ({rf_writeenable, rf_rd} !== 6'd0) begin mismatched++; $display("[TB] FAIL rr_idle: got we=%0b rd=%0d expected we=0 rd=0", rf_writeenable, rf_rd); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic_read;
      logic [5:0]  trace;
      logic        granted;
      int          lat;
      int          pulses;
      logic [18:0] data;
      writeReg(1'b0, 5'd5, 19'h7FFFF);
      runRead(5'd5, -1, 5'd0, 19'h0, trace, granted, lat, pulses, data);
      compared++; if (lat != 2) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d expected 2", lat); end
      compared++; if (pulses != 1) begin mismatched++; $display("[TB] FAIL basic_pulses: got %0d expected 1", pulses); end
      compared++; if (data !== 19'h7FFFF) begin mismatched++; $display("[TB] FAIL basic_data: got %05h expected 7ffff", data); end
      compared++; if (trace !== 6'b111001) begin mismatched++; $display("[TB] FAIL basic_ready_trace: got %06b expected 111001", trace); end
   endtask

   task automatic test_forwarding;
      logic [5:0]  trace;
      logic        granted;
      int          lat;
      int          pulses;
      logic [18:0] data;
      runRead(5'd9, 0, 5'd9, 19'h12345, trace, granted, lat, pulses, data);
      compared++; if (granted !== 1'b1) begin mismatched++; $display("[TB] FAIL fwd_write_accepted: got %0b expected 1", granted); end
      compared++; if (trace[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL fwd_read_accepted: got %0b expected 1", trace[0]); end
      compared++; if (lat != 2) begin mismatched++; $display("[TB] FAIL fwd_latency: got %0d expected 2", lat); end
      compared++; if (data !== 19'h12345) begin mismatched++; $display("[TB] FAIL fwd_data: got %05h expected 12345", data); end
   endtask

`ifdef REGFILE_CTRL_STATS_EN
   task automatic test_stats;
      compared++; if (stat_fwd_cnt !== 16'd1) begin mismatched++; $display("[TB] FAIL stat_fwd: got %0d expected 1", stat_fwd_cnt); end
      compared++; if (stat_rd_cnt !== 16'd2) begin mismatched++; $display("[TB] FAIL stat_rd: got %0d expected 2", stat_rd_cnt); end
      compared++; if (stat_wr0_cnt !== 16'd4) begin mismatched++; $display("[TB] FAIL stat_wr0: got %0d expected 4", stat_wr0_cnt); end
      compared++; if (stat_wr1_cnt !== 16'd2) begin mismatched++; $display("[TB] FAIL stat_wr1: got %0d expected 2", stat_wr1_cnt); end
   endtask
`endif

   task automatic test_read_before_write;
      logic [5:0]  trace;
      logic        granted;
      int          lat;
      int          pulses;
      logic [18:0] data;
      writeReg(1'b0, 5'd9, 19'h00001);
      runRead(5'd9, 1, 5'd9, 19'h00002, trace, granted, lat, pulses, data);
      compared++; if (granted !== 1'b1) begin mismatched++; $display("[TB] FAIL rbw_write_accepted: got %0b expected 1", granted); end
      compared++; if (data !== 19'h00001) begin mismatched++; $display("[TB] FAIL rbw_old_data: got %05h expected 00001", data); end
      runRead(5'd9, -1, 5'd0, 19'h0, trace, granted, lat, pulses, data);
      compared++; if (lat != 2) begin mismatched++; $display("[TB] FAIL rbw_latency: got %0d expected 2", lat); end
      compared++; if (data !== 19'h00002) begin mismatched++; $display("[TB] FAIL rbw_new_data: got %05h expected 00002", data); end
   endtask

   task automatic test_zero_register;
      logic [5:0]  trace;
      logic        granted;
      int          lat;
      int          pulses;
      logic [18:0] data;
      wr1_valid = 1'b1; wr1_addr = 5'd0; wr1_data = 19'h55555;
      @(negedge clk);
      compared++; if (wr1_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_wr1_ready: got %0b expected 1", wr1_ready); end
      @(posedge clk); #1;
      wr1_valid = 1'b0;
      @(negedge clk);
      compared++; if (rf_writeenable !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_we: got %0b expected 0", rf_writeenable); end
      compared++; if (rf_aluresult !== 19'h00002) begin mismatched++; $display("[TB] FAIL zero_alu_hold: got %05h expected 00002", rf_aluresult); end
      @(posedge clk); #1;
      runRead(5'd0, -1, 5'd0, 19'h0, trace, granted, lat, pulses, data);
      compared++; if (lat != 2) begin mismatched++; $display("[TB] FAIL zero_latency: got %0d expected 2", lat); end
      compared++; if (data !== 19'h0) begin mismatched++; $display("[TB] FAIL zero_data: got %05h expected 00000", data); end
   endtask

   task automatic test_reset_mid_read;
      int pulses;
      pulses   = 0;
      rd_valid = 1'b1; rd_addr = 5'd3;
      wr0_valid = 1'b1; wr0_addr = 5'd3; wr0_data = 19'h33333;
      @(negedge clk);
      compared++; if ({rd_ready, wr0_ready} !== 2'b11) begin mismatched++; $display("[TB] FAIL mid_handshake: got %02b expected 11", {rd_ready, wr0_ready}); end
      @(posedge clk); #1;
      rd_valid = 1'b0; wr0_valid = 1'b0;
      @(negedge clk);
      compared++; if ({rd_ready, rf_writeenable} !== 2'b01) begin mismatched++; $display("[TB] FAIL mid_issue: got ready/we %02b expected 01", {rd_ready, rf_writeenable}); end
      #1 reset_n = 1'b0;
      #1;
      compared++; if (rd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_reset_ready: got %0b expected 1", rd_ready); end
      compared++; if (rf_writeenable !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_we: got %0b expected 0", rf_writeenable); end
      compared++; if (rd_data_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_dv: got %0b expected 0", rd_data_valid); end
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
         if (rd_data_valid) pulses++;
      end
      compared++; if (pulses != 0) begin mismatched++; $display("[TB] FAIL mid_no_data_valid: got %0d pulses expected 0", pulses); end
      compared++; if (rd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_after_ready: got %0b expected 1", rd_ready); end
      @(posedge clk); #1;
   endtask

   // Test sequence; the watchdog below bounds the whole run.
   initial begin
      tbInit    = 1'b1;
      reset_n   = 1'b1;
      wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
      wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
      rd_valid  = 1'b0; rd_addr  = '0;
      test_reset();
      test_round_robin();
      test_basic_read();
      test_forwarding();
`ifdef REGFILE_CTRL_STATS_EN
      test_stats();
`endif
      test_read_before_write();
      test_zero_register();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Hard time limit in case the sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Sequences all accesses to the 32 x 19-bit register file.
- Arbitrates two write requesters (ALU writeback = wr0, load/immediate unit = wr1) onto the single write port using round-robin.
- Runs a 2-cycle read transaction on the rs read port.
- Forwards a write that lands in the same cycle the register file samples the read address.

Parameters:
- DATA_W, 19, register data width
- ADDR_W, 5, register address width (32 entries, entry 0 hardwired zero)
- CNT_W, 16, width of statistics counters (optional feature only)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- wr0_valid  in  1  write request, requester 0
- wr0_ready  out  1  grant to requester 0; transfer when valid&&ready
- wr0_addr  in  ADDR_W  destination register, requester 0
- wr0_data  in  DATA_W  write data, requester 0
- wr1_valid  in  1  write request, requester 1
- wr1_ready  out  1  grant to requester 1
- wr1_addr  in  ADDR_W  destination register, requester 1
- wr1_data  in  DATA_W  write data, requester 1
- rd_valid  in  1  read request
- rd_ready  out  1  controller can accept a read
- rd_addr  in  ADDR_W  register to read
- rd_data_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  DATA_W  read result
- rf_writeenable  out  1  to register file writeenable
- rf_rd  out  ADDR_W  to register file rd
- rf_rs  out  ADDR_W  to register file rs
- rf_aluresult  out  DATA_W  to register file aluresult
- rf_regdata1  in  DATA_W  from register file regdata1; registered there, 1-cycle latency after rs

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0 except rd_ready=1.
  - FSM=IDLE, RR pointer favours wr0, forward flag cleared.
  - An in-flight read is dropped with no rd_data_valid.
- Write arbitration (combinational ready, one grant per cycle):
  - If only one valid, that requester gets ready.
  - If both valid, the favoured requester gets ready; after a grant to k, the other requester is favoured.
  - The pointer is unchanged in cycles with no grant.
  - The write port never stalls: exactly one valid requester is granted every cycle either is valid.
- Write path, registered stage:
  - Transfer in cycle N gives rf_writeenable=1 with rf_rd/rf_aluresult in cycle N+1; the register file updates at the end of N+1.
  - Writes to addr 0 are consumed (ready given) but drive rf_writeenable=0.
  - When idle: rf_writeenable=0, rf_rd=0, rf_aluresult holds its last value.
- Read FSM:
  - IDLE: rd_ready=1. On rd_valid in cycle N, register rf_rs=rd_addr and go to ISSUE.
  - ISSUE (cycle N+1): rd_ready=0; the register file samples rf_rs at the end of this cycle.
    - If rf_writeenable && rf_rd==rf_rs in this cycle, capture rf_aluresult into the forward register and set the forward flag. That write is not yet visible to the sampled data.
    - Next state: DATA.
  - DATA (cycle N+2): rd_data_valid=1.
    - rd_data = forward register if the flag is set, else rf_regdata1.
    - rd_addr==0 always returns 0.
    - Clear the flag and go to IDLE; rd_ready=1 again in N+3.
  - Throughput: one read per 3 cycles.
- Ordering:
  - Writes transferred in or before cycle N are visible to a read handshaken in N.
  - Writes transferred in N+1 or later are not visible to it (read-before-write).
- Simultaneous read and write handshakes in the same cycle are both accepted.
- rf_rs holds its value outside ISSUE.

Optional Feature:
- Macro REGFILE_CTRL_STATS_EN.
- Defined: adds outputs stat_wr0_cnt, stat_wr1_cnt, stat_rd_cnt, stat_fwd_cnt, each CNT_W wide.
  - Counters saturate at all-ones and clear on reset.
  - They increment on wr0 grant, wr1 grant, rd handshake, and forward capture respectively.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-read:
  - Stimulus: read addr 3 handshaken, reset_n low during ISSUE.
  - Response: rd_data_valid never asserts, rd_ready=1, rf_writeenable=0.
- Round-robin contention:
  - Stimulus: wr0 and wr1 both held valid (addr 1, 0x00011 / addr 2, 0x00022) for 4 cycles.
  - Response: grants alternate wr0, wr1, wr0, wr1; rf_rd sequence 1,2,1,2 one cycle later.
- Basic read:
  - Stimulus: write addr 5 = 0x7FFFF, wait 2 cycles, read addr 5.
  - Response: rd_data_valid exactly 2 cycles after handshake, rd_data=0x7FFFF, rd_ready low for 2 cycles.
- Forwarding:
  - Stimulus: write addr 9 = 0x12345 transferred in the same cycle as read-addr-9 handshake.
  - Response: rd_data=0x12345 (forwarded); stat_fwd_cnt=1 if REGFILE_CTRL_STATS_EN.
- Read-before-write:
  - Stimulus: addr 9 holds 0x00001; read 9 handshaken, write 9 = 0x00002 in the following cycle.
  - Response: rd_data=0x00001; a later read returns 0x00002.
- Zero register:
  - Stimulus: wr1 writes addr 0 = 0x55555, then read addr 0.
  - Response: wr1_ready=1, rf_writeenable stays 0, rd_data=0.
